// File: rtl/xbar_rr_arbiter_if.sv
// Request/grant bundle between the masters routed to one slave port
// and that port's round-robin arbiter.
interface xbar_rr_arbiter_if #(
   parameter int N = 2
);
   localparam int IDW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]   req;
   logic           ack_in;
   logic [N-1:0]   grant;
   logic           grant_valid;
   logic [IDW-1:0] grant_id;
   logic           timeout_err;

   modport master (
      output req, ack_in,
      input  grant, grant_valid, grant_id, timeout_err
   );

   modport slave (
      input  req, ack_in,
      output grant, grant_valid, grant_id, timeout_err
   );
endinterface

// File: rtl/xbar_rr_arbiter.sv
// Registered round-robin arbiter with transaction lock and watchdog
// for one crossbar slave port.
module xbar_rr_arbiter #(
   parameter int N       = 2,
   parameter int TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst,
   xbar_rr_arbiter_if.slave bus
);
   localparam int IDW = (N > 1) ? $clog2(N) : 1;
   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDW-1:0] WD_LAST =
      WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [WDW-1:0] WD_MAX = '1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state;
   logic [N-1:0]   grant_q;
   logic           valid_q;
   logic [IDW-1:0] id_q;
   logic           terr_q;
   logic [IDW-1:0] ptr;
   logic [WDW-1:0] wd;

   logic [IDW:0]   p_free;
   logic [IDW:0]   p_ack;
   logic           wd_hit;

   // {found, index}; nearest set bit after start, wrapping mod N
   function automatic logic [IDW:0] pick(
      input logic [N-1:0]   r,
      input logic [IDW-1:0] start
   );
      logic [IDW:0] res;
      int j;
      res = '0;
      for (int i = N; i >= 1; i--) begin
         j = (int'(start) + i) % N;
         if (r[j]) res = {1'b1, IDW'(j)};
      end
      return res;
   endfunction

   function automatic logic [N-1:0] onehot(
      input logic [IDW-1:0] idx
   );
      logic [N-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   always_comb begin
      p_free = pick(bus.req, ptr);
      p_ack  = pick(bus.req & ~grant_q, id_q);
      wd_hit = (TIMEOUT != 0) && (wd == WD_LAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         grant_q <= '0;
         valid_q <= 1'b0;
         id_q    <= '0;
         terr_q  <= 1'b0;
         ptr     <= IDW'(N - 1);
         wd      <= '0;
      end else begin
         terr_q <= 1'b0;
         unique case (state)
            IDLE: begin
               wd <= '0;
               if (p_free[IDW]) begin
                  grant_q <= onehot(p_free[IDW-1:0]);
                  id_q    <= p_free[IDW-1:0];
                  valid_q <= 1'b1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (bus.ack_in) begin
                  ptr <= id_q;
                  wd  <= '0;
                  if (p_ack[IDW]) begin
                     grant_q <= onehot(p_ack[IDW-1:0]);
                     id_q    <= p_ack[IDW-1:0];
                  end else begin
                     grant_q <= '0;
                     id_q    <= '0;
                     valid_q <= 1'b0;
                     state   <= IDLE;
                  end
               end else if (!bus.req[id_q]) begin
                  // master abort: no service credited, ptr kept
                  wd <= '0;
                  if (p_free[IDW]) begin
                     grant_q <= onehot(p_free[IDW-1:0]);
                     id_q    <= p_free[IDW-1:0];
                  end else begin
                     grant_q <= '0;
                     id_q    <= '0;
                     valid_q <= 1'b0;
                     state   <= IDLE;
                  end
               end else if (wd_hit) begin
                  terr_q  <= 1'b1;
                  ptr     <= id_q;
                  wd      <= '0;
                  grant_q <= '0;
                  id_q    <= '0;
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end else if (TIMEOUT != 0 && wd != WD_MAX) begin
                  wd <= wd + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = valid_q;
   assign bus.grant_id    = id_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: doc/xbar_rr_arbiter.md
# xbar_rr_arbiter

Clocked round-robin arbiter with transaction lock for one slave port of the 2x2 master/slave crossbar. It takes one request per master routed to this slave and issues a registered one-hot grant that steers the slave-side mux. The grant is held until the slave acks or a watchdog expires. One instance per slave port, replacing the combinational arbiter; grant drives the existing slave mux unchanged.

## Interface
- N, default 2: number of requesters (2..8).
- TIMEOUT, default 256: cycles without ack before forced release; 0 disables the watchdog.
- IDW (localparam): max(1, $clog2(N)).

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; one clock, no other clock domains.
- req  input  N  request per master; bit i = master i (crossbar wiring keeps existing bit order).
- ack_in  input  1  slave ack; ends the granted transaction.
- grant  output  N  registered one-hot grant, all-zero when idle.
- grant_valid  output  1  OR of grant, registered.
- grant_id  output  IDW  index of the granted master; 0 when idle.
- timeout_err  output  1  one-cycle pulse on watchdog release.

## Operation
- States: IDLE, BUSY.
- Round-robin pointer ptr (IDW bits) holds the last served index. Search order is ptr+1, ptr+2, … wrapping modulo N, so the last served requester has lowest priority.
- IDLE:
  - If any req bit is set, pick the first set bit in search order.
  - Load grant/grant_id and go to BUSY.
  - ptr is not changed yet.
- BUSY, ack_in=1:
  - ptr <= grant_id and the watchdog clears.
  - Re-arbitrate in the same cycle over req with the current grant_id bit masked out.
  - If a winner exists, grant it next cycle and stay in BUSY (back-to-back). Otherwise go to IDLE with grant=0.
- BUSY, req[grant_id]=0 and ack_in=0 (master abort): release without updating ptr. Re-arbitrate as for ack, with no mask.
- BUSY, watchdog reaches TIMEOUT-1 with no ack:
  - Pulse timeout_err.
  - ptr <= grant_id and go to IDLE with grant=0.
  - Masking as for ack.
- Watchdog: counter of $clog2(TIMEOUT+1) bits. Increments each BUSY cycle without ack and saturates. It is held at 0 when TIMEOUT=0.
- ack_in is ignored in IDLE.
- Reset values: state=IDLE, grant=0, grant_valid=0, grant_id=0, timeout_err=0, ptr=N-1 (so requester 0 wins first), watchdog=0.
- Reset is asserted asynchronously; deassertion must be synchronized upstream.
- Reset mid-transaction drops the grant immediately; no ack is owed.

## Timing
- Request-to-grant latency: req rises at edge t (IDLE) -> grant valid after edge t+1.
- Ack at cycle k: grant moves to the next winner or to 0 after edge k+1. There are no idle cycles between back-to-back grants.
- Grant is stable for the whole BUSY interval; it changes only at ack, abort, timeout or reset.
- Simultaneous ack_in and timeout in the same cycle: ack wins, no timeout_err.
- Simultaneous ack_in and abort: treated as ack.
- Outputs are all registered; no combinational path from req or ack_in to grant.

## Test plan
- Reset -> grant=00, grant_valid=0, grant_id=0, timeout_err=0. Then req=11 -> grant=01 (master 0) after one edge.
- Fairness: req=11 held, ack_in pulsed one cycle per transaction -> grants alternate 01,10,01,10 with no idle cycle between them.
- Single requester: req=01, ack at cycle k, req drops at k+1 -> grant=00 after edge k+1, no spurious re-grant of master 0.
- Timeout (TIMEOUT=4): req=10, no ack -> timeout_err pulses on the 4th BUSY cycle, grant=00 next edge. A subsequent req=11 then grants master 0.
- Abort: grant=01, req goes 01->00 with no ack -> grant=00 after one edge, ptr unchanged. A later req=11 grants master 1 only if master 0 was served before.
- Async reset: assert rst=0 mid-BUSY between clock edges -> grant=00 immediately, without waiting for a clock edge.
